start_debouncer: RTL and testbench



---
 rtl/ohsm_pkg.sv | 15 +
 rtl/start_debouncer_sync_ff.sv | 21 ++
 rtl/start_debouncer.sv | 88 ++++++++
 tb/tb_start_debouncer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ohsm_pkg.sv
// Shared types and constants for the ohsm start path.
// The debouncer state type lives here so ohsm-side debug logic can decode it.
package ohsm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM_HI,
    PRESSED,
    ARM_LO
  } db_state_t;

  localparam int DB_CNT_MAX_SIM   = 20;
  localparam int DB_CNT_MAX_BOARD = 1_000_000;

endpackage

// File: rtl/start_debouncer_sync_ff.sv
// N-flop synchronizer for a single asynchronous bit.
// Plain flop chain with asynchronous clear to 0.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ff <= '0;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/start_debouncer.sv
// Push-button conditioner: synchronize, debounce, and emit one start pulse per press.
// Also exports the debounced level and a wrapping press counter.
module start_debouncer
  import ohsm_pkg::*;
#(
  parameter int CNT_MAX     = DB_CNT_MAX_SIM,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       start,
  output logic       btn_level,
  output logic [7:0] press_count
);

  localparam int          CW       = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic          btn_sync;
  db_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          press_nx, release_nx;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_raw),
    .q    (btn_sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // A level flip is accepted only after the counter runs out with no opposite sample.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    case (state)
      IDLE: if (btn_sync) begin
        state_nx = ARM_HI;
        cnt_nx   = '0;
      end
      ARM_HI: begin
        if (!btn_sync)            state_nx = IDLE;
        else if (cnt == CNT_LAST) begin
          state_nx = PRESSED;
          press_nx = 1'b1;
        end else                  cnt_nx = cnt + CW'(1);
      end
      PRESSED: if (!btn_sync) begin
        state_nx = ARM_LO;
        cnt_nx   = '0;
      end
      ARM_LO: begin
        if (btn_sync)             state_nx = PRESSED;
        else if (cnt == CNT_LAST) begin
          state_nx   = IDLE;
          release_nx = 1'b1;
        end else                  cnt_nx = cnt + CW'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start       <= 1'b0;
      btn_level   <= 1'b0;
      press_count <= '0;
    end else begin
      start <= press_nx;
      if (press_nx)        btn_level <= 1'b1;
      else if (release_nx) btn_level <= 1'b0;
      if (press_nx) press_count <= press_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_start_debouncer.sv
// Scoreboard bench for start_debouncer: a run-length reference model queues
// expected press/level events, a monitor pops them when the DUT shows them.
module tb_start_debouncer;

  localparam int CM = 4;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_raw = 1'b0;
  logic       start;
  logic       btn_level;
  logic [7:0] press_count;

  always #5 clk = ~clk;

  start_debouncer #(.CNT_MAX(CM), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .start      (start),
    .btn_level  (btn_level),
    .press_count(press_count)
  );

  typedef struct { int v; int e; } ev_t;
  ev_t pq[$];
  ev_t lq[$];

  int total = 0, bad = 0;
  int edge_n = 0;
  int starts_seen = 0, presses_model = 0, last_start_edge = -1;
  int m_lvl = 0, m_run = 0, m_cnt = 0;
  int sh[SS];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    btn_raw = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    #2 reset = 1'b1;
    #1;
    check("rst_start", int'(start), 0);
    check("rst_level", int'(btn_level), 0);
    check("rst_count", int'(press_count), 0);
    repeat (n) @(negedge clk);
    #2 reset = 1'b0;
  endtask

  // Reference: the level flips once the synchronized input has disagreed
  // with it for CM+1 consecutive sampled edges.
  task automatic model_loop();
    forever begin
      @(posedge clk);
      edge_n++;
      if (reset) begin
        m_lvl = 0; m_run = 0; m_cnt = 0;
        foreach (sh[i]) sh[i] = 0;
      end else begin
        int s;
        s = sh[SS-1];
        if (s != m_lvl) begin
          m_run++;
          if (m_run == CM + 1) begin
            m_lvl = s;
            m_run = 0;
            lq.push_back('{s, edge_n});
            if (s != 0) begin
              m_cnt = (m_cnt + 1) % 256;
              presses_model++;
              pq.push_back('{m_cnt, edge_n});
            end
          end
        end else m_run = 0;
        for (int i = SS - 1; i > 0; i--) sh[i] = sh[i-1];
        sh[0] = int'(btn_raw);
      end
    end
  endtask

  task automatic monitor_loop();
    int prev_lvl = 0, prev_start = 0;
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_lvl = 0; prev_start = 0;
      end else begin
        if (start) begin
          starts_seen++;
          last_start_edge = edge_n;
          check("start_width", prev_start, 0);
          if (pq.size() == 0) check("unexpected_start", 1, 0);
          else begin
            e = pq.pop_front();
            check("start_edge", edge_n, e.e);
            check("press_count", int'(press_count), e.v);
          end
        end
        if (int'(btn_level) != prev_lvl) begin
          if (lq.size() == 0) check("unexpected_level", int'(btn_level), prev_lvl);
          else begin
            e = lq.pop_front();
            check("level_val", int'(btn_level), e.v);
            check("level_edge", edge_n, e.e);
          end
          prev_lvl = int'(btn_level);
        end
        if (pq.size() != 0) begin check("missed_start", 0, 1); pq.delete(); end
        if (lq.size() != 0) begin check("missed_level", 0, 1); lq.delete(); end
        prev_start = int'(start);
      end
    end
  endtask

  initial begin
    int rise, s0;
    foreach (sh[i]) sh[i] = 0;
    fork
      model_loop();
      monitor_loop();
    join_none

    repeat (2) @(negedge clk);
    check("reset_start", int'(start), 0);
    check("reset_level", int'(btn_level), 0);
    check("reset_count", int'(press_count), 0);
    reset = 1'b0;

    // clean press
    rise = edge_n;
    hold(1'b1, 20);
    check("t1_latency", last_start_edge, rise + 7);
    check("t1_count", int'(press_count), 1);
    check("t1_level", int'(btn_level), 1);
    hold(1'b0, 15);
    check("t1_release", int'(btn_level), 0);

    // glitch rejection and bounce trains
    do_reset(2);
    s0 = starts_seen;
    hold(1'b1, 3);
    hold(1'b0, 10);
    check("t2_glitch_starts", starts_seen - s0, 0);
    check("t2_glitch_level", int'(btn_level), 0);
    check("t2_glitch_count", int'(press_count), 0);
    for (int k = 0; k < 3; k++) begin
      hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1);
    end
    hold(1'b1, 15);
    check("t2_bounce_pulses", starts_seen - s0, 1);

    // release bounce
    s0 = starts_seen;
    hold(1'b0, 2);
    hold(1'b1, 1);
    hold(1'b0, 3);
    check("t3_level_held", int'(btn_level), 1);
    hold(1'b0, 20);
    check("t3_level_low", int'(btn_level), 0);
    check("t3_no_extra", starts_seen - s0, 0);

    // long hold
    do_reset(2);
    s0 = starts_seen;
    hold(1'b1, 100);
    check("t4_pulses", starts_seen - s0, 1);
    check("t4_count", int'(press_count), 1);
    hold(1'b0, 15);

    // wrap of press_count
    do_reset(2);
    s0 = starts_seen;
    for (int k = 0; k < 256; k++) begin
      if ($urandom_range(0, 1) == 1) begin hold(1'b1, 1); hold(1'b0, 1); end
      hold(1'b1, CM + 4 + int'($urandom_range(0, 4)));
      hold(1'b0, CM + 4 + int'($urandom_range(0, 4)));
    end
    check("t5_wrap_count", int'(press_count), 0);
    check("t5_pulses", starts_seen - s0, 256);

    // reset while arming, button still held
    hold(1'b1, 4);
    do_reset(2);
    rise = edge_n;
    s0 = starts_seen;
    hold(1'b1, 20);
    check("t6_latency", last_start_edge, rise + 7);
    check("t6_count", int'(press_count), 1);
    check("t6_pulses", starts_seen - s0, 1);
    hold(1'b0, 15);

    // reset landing on the pulse cycle
    hold(1'b1, 7);
    check("t6_pulse_seen", int'(start), 1);
    do_reset(2);
    hold(1'b0, 15);

    // random bouncing
    for (int k = 0; k < 300; k++)
      hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
    hold(1'b0, 20);

    check("pending_events", pq.size() + lq.size(), 0);
    check("total_starts", starts_seen, presses_model);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
